// File: rtl/fft_sample_ram.sv
// Simple-dual-port frame sample memory with a sequenced zeroing clear and registered read port.
// Optional FFT_RAM_BITREV_EN: write address is bit-reversed so frames read back in bit-reversed order.
module fft_sample_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] waddr_eff;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef FFT_RAM_BITREV_EN
  always_comb begin
    waddr_eff = '0;
    for (int i = 0; i < ADDR_W; i++) waddr_eff[i] = wr_addr[ADDR_W-1-i];
  end
`else
  assign waddr_eff = wr_addr;
`endif

  // NOTE: the array has no reset branch so it maps onto block RAM; zeroing
  // is done one word per cycle by the CLEAR sequence instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else if (wr_en)     mem[waddr_eff] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments make the read below sample the pre-write
  // contents, which is what gives the read-first collision behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      busy     <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rd_valid <= 1'b0;
          clr_cnt  <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          rd_valid <= rd_en;
          if (rd_en) rd_data <= mem[rd_addr];
          // A write and a read in this same cycle still complete before the clear.
          if (clear) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
